// File: rtl/wb_pkg.sv
// Shared widths and the buffered writeback entry type for the writeback arbiter.
package wb_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding LSU writeback entries until the arbiter grants them.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    wb_entry_t   mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra pointer MSB separates the full and empty cases when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU-priority merge of ALU and buffered LSU results with a starvation guard
// and a pending-write scoreboard. Define WB_FWD_EN to add rs1_fwd/rs2_fwd forwarding outputs.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN       = wb_pkg::XLEN,
    parameter int REG_AW     = wb_pkg::REG_AW,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              issue_set,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
`ifdef WB_FWD_EN
    output logic              rs1_fwd,
    output logic              rs2_fwd,
`endif
    output logic              we,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   rd_data
);
    localparam int NREG   = 2**REG_AW;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    wb_entry_t         lsu_entry;
    wb_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              lsu_push;
    logic              force_lsu;
    logic              alu_grant;
    logic              lsu_grant;
    logic [WAIT_W-1:0] wait_cnt;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic              vld_p0;
    logic [REG_AW-1:0] rd_p0;
    logic [XLEN-1:0]   data_p0;
    logic              inflight1;
    logic              inflight2;

    assign lsu_entry = '{rd: lsu_rd, data: lsu_data};
    assign lsu_ready = !fifo_full;
    assign lsu_push  = lsu_valid && !fifo_full;

    wb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (lsu_push),
        .din   (lsu_entry),
        .pop   (lsu_grant),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Grant: a starved LSU head beats the ALU, otherwise the ALU has priority.
    assign force_lsu = !fifo_empty && (wait_cnt == WAIT_W'(MAX_WAIT));
    assign alu_ready = !force_lsu;
    assign alu_grant = !force_lsu && alu_valid;
    assign lsu_grant = force_lsu || (!alu_valid && !fifo_empty);

    always_comb begin
        vld_p0  = 1'b0;
        rd_p0   = '0;
        data_p0 = '0;
        if (lsu_grant) begin
            vld_p0  = 1'b1;
            rd_p0   = head.rd;
            data_p0 = head.data;
        end else if (alu_grant) begin
            vld_p0  = 1'b1;
            rd_p0   = alu_rd;
            data_p0 = alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (fifo_empty || lsu_grant)
            wait_cnt <= '0;
        else if (alu_grant && wait_cnt != WAIT_W'(MAX_WAIT))
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    // Set is applied after clear so a same-cycle issue to the retiring index stays pending.
    always_comb begin
        pending_nxt = pending;
        if (lsu_grant)
            pending_nxt[head.rd] = 1'b0;
        if (issue_set)
            pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    // Stage p0 -> registered register-file write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we      <= 1'b0;
            rd      <= '0;
            rd_data <= '0;
        end else begin
            we <= vld_p0 && (rd_p0 != '0);
            if (vld_p0) begin
                rd      <= rd_p0;
                rd_data <= data_p0;
            end
        end
    end

    assign inflight1 = we && (rd == chk_rs1) && (rd != '0);
    assign inflight2 = we && (rd == chk_rs2) && (rd != '0);

`ifdef WB_FWD_EN
    assign rs1_fwd  = inflight1;
    assign rs2_fwd  = inflight2;
    assign rs1_busy = pending[chk_rs1];
    assign rs2_busy = pending[chk_rs2];
`else
    // The register file only updates at the edge after we, so the in-flight write still counts as busy.
    assign rs1_busy = pending[chk_rs1] || inflight1;
    assign rs2_busy = pending[chk_rs2] || inflight2;
`endif
endmodule
